// File: rtl/kara_overlap_accum_if.sv
// Handshake bundle between the half-size sub-multipliers (master side)
// and the Karatsuba overlap/recombination accumulator (slave side).
interface kara_overlap_accum_if #(
  parameter int N = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_tag;
  logic [N-2:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-2:0]   out_data;
  logic             err;

  modport master (
    output in_valid, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data, err
  );
endinterface

// File: rtl/kara_overlap_accum.sv
// Karatsuba overlap/recombination stage for carry-less GF(2) multiplication.
// Collects lo/mid/hi partial products (tagged, any order), then XOR-overlaps
// them at offsets 0, N/2 and N into one 2N-1 bit product.
module kara_overlap_accum #(
  parameter int N       = 16,
  parameter bit CORRECT = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 clr,
  kara_overlap_accum_if.slave bus
);
  localparam int H = N / 2;
  localparam int W = N - 1;
  localparam int P = 2 * N - 1;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [2:0]     mask_reg, mask_next;
  logic [W-1:0]   lo_reg, lo_next;
  logic [W-1:0]   mid_reg, mid_next;
  logic [W-1:0]   hi_reg, hi_next;
  logic [P-1:0]   out_data_reg, out_data_next;
  logic           err_reg, err_next;

  logic [2:0]     tag_bit;
  logic           accept;
  logic [W-1:0]   lo_eff, mid_eff, hi_eff, m_eff;
  logic [P-1:0]   product;

  assign bus.in_ready  = (state_reg == COLLECT);
  assign bus.out_valid = (state_reg == OUTPUT);
  assign bus.out_data  = out_data_reg;
  assign bus.err       = err_reg;

  // Next-state, partial storage and recombination; the completing partial
  // is bypassed straight from in_data so the product is ready one cycle later.
  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    lo_next       = lo_reg;
    mid_next      = mid_reg;
    hi_next       = hi_reg;
    out_data_next = out_data_reg;
    err_next      = 1'b0;

    tag_bit = 3'b000;
    case (bus.in_tag)
      2'b00:   tag_bit = 3'b001;
      2'b01:   tag_bit = 3'b010;
      2'b10:   tag_bit = 3'b100;
      default: tag_bit = 3'b000;
    endcase

    accept  = bus.in_valid && (state_reg == COLLECT) && !clr;
    lo_eff  = (accept && tag_bit[0]) ? bus.in_data : lo_reg;
    mid_eff = (accept && tag_bit[1]) ? bus.in_data : mid_reg;
    hi_eff  = (accept && tag_bit[2]) ? bus.in_data : hi_reg;
    m_eff   = CORRECT ? (mid_eff ^ lo_eff ^ hi_eff) : mid_eff;
    product = {{N{1'b0}}, lo_eff}
            ^ ({{N{1'b0}}, m_eff} << H)
            ^ ({{N{1'b0}}, hi_eff} << N);

    if (clr) begin
      mask_next  = 3'b000;
      state_next = COLLECT;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            if (tag_bit == 3'b000) begin
              // Illegal tag: data discarded, mask untouched.
              err_next = 1'b1;
            end else begin
              if ((tag_bit & mask_reg) != 3'b000) err_next = 1'b1;
              lo_next   = lo_eff;
              mid_next  = mid_eff;
              hi_next   = hi_eff;
              mask_next = mask_reg | tag_bit;
              if ((mask_reg | tag_bit) == 3'b111) begin
                state_next    = OUTPUT;
                out_data_next = product;
              end
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            mask_next  = 3'b000;
            state_next = COLLECT;
          end
        end
        default: begin
          mask_next  = 3'b000;
          state_next = COLLECT;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= COLLECT;
      mask_reg     <= 3'b000;
      lo_reg       <= '0;
      mid_reg      <= '0;
      hi_reg       <= '0;
      out_data_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      lo_reg       <= lo_next;
      mid_reg      <= mid_next;
      hi_reg       <= hi_next;
      out_data_reg <= out_data_next;
      err_reg      <= err_next;
    end
  end
endmodule

// File: doc/kara_overlap_accum.md
Name: kara_overlap_accum

Overview:
- Parametrised, sequential successor to the 16-bit Karatsuba overlap/recombination stage for carry-less GF(2) multiplication.
- Collects the three half-size partial products (low, middle, high) over a tagged valid/ready input, in any order. It then XOR-overlaps them at offsets 0, N/2 and N and presents one 2N-1-bit product on a valid/ready output.
- Optionally performs the Karatsuba middle-term correction internally (mid ^ lo ^ hi).
- Sits between the N/2-bit sub-multipliers and the next recursion level of the KA tree.

Parameters:
- N, 16, operand width in bits; even, >= 4. Partial products are N-1 bits; product is 2N-1 bits. H = N/2.
- CORRECT, 0, 0: middle input is already corrected. 1: block XORs lo and hi into the middle before overlapping.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: drops stored partials and any pending result
- in_valid  in  1  partial product present
- in_ready  out  1  block can accept a partial product
- in_tag  in  2  00 = lo, 01 = mid, 10 = hi, 11 = illegal
- in_data  in  N-1  partial product
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product
- out_data  out  2N-1  recombined product
- err  out  1  one-cycle pulse on a duplicate or illegal tag

Behaviour:
- Reset (rst_n low, async): state = COLLECT; received mask = 000; lo/mid/hi registers = 0; out_valid = 0; out_data = 0; err = 0; in_ready = 1 once reset is released.
- Input handshake: accept when in_valid && in_ready at the rising edge.
- in_ready = 1 in COLLECT, 0 in OUTPUT.
- COLLECT:
  - An accepted tag 00/01/10 stores in_data in the matching register and sets its mask bit.
  - A tag already in the mask: new data replaces the stored value and err pulses the next cycle.
  - Tag 11: data discarded, mask unchanged, err pulses.
- Transition to OUTPUT: on the edge where an accept completes the mask (111), out_data is computed from stored values plus the incoming in_data, and out_valid = 1 from the next cycle.
  - Latency: 1 cycle from the final accept to out_valid.
- Recombination, where m = mid (CORRECT=0) or mid ^ lo ^ hi (CORRECT=1):
  - out_data = lo ^ (m << H) ^ (hi << N), all zero-extended to 2N-1 bits.
  - Resulting bit map: bits 0..H-1 = lo only; H..N-2 = lo ^ m; N-1 = m[H-1] only; N..N+H-2 = m ^ hi; N+H-1..2N-2 = hi only.
- OUTPUT:
  - out_valid and out_data are held stable until out_valid && out_ready.
  - On that handshake: mask cleared, state = COLLECT, out_valid = 0 the next cycle.
  - No input is accepted in the handshake cycle, because in_ready = 0 in OUTPUT.
- out_ready high while out_valid = 0 has no effect.
- clr = 1 takes priority over every handshake in that cycle:
  - mask cleared, out_valid = 0, state = COLLECT, err = 0 next cycle;
  - partial registers are not required to be zeroed;
  - an in_valid in the same cycle is dropped.
- Async reset mid-operation: immediate return to reset values; a partial set or pending product is lost.
- No back-pressure bubble beyond the above: a new triple can complete at most once every 4 cycles (3 accepts + 1 output handshake).

Test Plan:
- N=16, CORRECT=0; tags lo=0x0003, mid=0x0005, hi=0x0006 on consecutive cycles, out_ready=1 -> out_valid one cycle after the hi accept, out_data = 0x60503; then in_ready = 1.
- N=16, CORRECT=1; same three inputs sent in order hi, lo, mid -> m = 0, out_data = 0x60003; order independence confirmed.
- N=16, CORRECT=0; lo=0x7F00, mid=0x007F, hi=0x0000 -> overlap cancels, out_data = 0x0; then lo=0x00FF, mid=0x00FF, hi=0 -> out_data = 0xFFFF.
- Back-pressure: complete a triple with out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready = 0 with in_valid = 1 and no accept; raise out_ready -> one handshake, then COLLECT.
- Errors: send lo=0x0001, lo=0x0002 (duplicate), tag 11 data 0x7FFF, mid=0, hi=0 -> err pulses twice; out_data = 0x2.
- Clear/reset: accept lo and mid, assert clr with in_valid on a hi -> hi dropped, mask empty; then apply a full triple -> normal result. Pull rst_n low while out_valid=1 -> out_valid and out_data go to 0 immediately.
